// File: rtl/game_pkg.sv
// game_pkg: shared definitions for the turn sequencer slice.
//   - ball count and cue-ball index
//   - turn state encoding
//   - winner encoding and small score helpers
package game_pkg;

  localparam int NUMBER_OF_BALLS = 11;
  localparam int CUE_BALL        = 0;

  localparam logic [3:0] SCORE_MAX = 4'd10;

  typedef enum logic [2:0] {
    S_AIM,
    S_ROLL,
    S_RESOLVE,
    S_RESPOT,
    S_OVER
  } turnState_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P0   = 2'b01;
  localparam logic [1:0] WIN_P1   = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

  // Score add that clamps at the number of object balls.
  function automatic logic [3:0] satAdd(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, SCORE_MAX}) ? SCORE_MAX : s[3:0];
  endfunction

  function automatic logic [1:0] winnerOf(input logic [3:0] s0, input logic [3:0] s1);
    if (s0 > s1)      return WIN_P0;
    else if (s1 > s0) return WIN_P1;
    else              return WIN_TIE;
  endfunction

endpackage

// File: rtl/still_detector.sv
// still_detector: frame counters that decide when a rolling shot is over.
//   clk, resetN     clock / async active-low reset
//   clear           hold counters at zero (outside the rolling phase)
//   startOfFrame    one-cycle frame tick
//   no_moving_flag  all ball velocities are zero
//   settled         pulse: SETTLE_FRAMES consecutive still frames seen
//   timeout         pulse: MAX_ROLL_FRAMES frames rolled without settling
// Both pulses are combinational in the frame-tick cycle so the owner can
// register its state change on that same edge. Settle has priority.
module still_detector #(
  parameter int SETTLE_FRAMES   = 4,
  parameter int MAX_ROLL_FRAMES = 1800
) (
  input  logic clk,
  input  logic resetN,
  input  logic clear,
  input  logic startOfFrame,
  input  logic no_moving_flag,
  output logic settled,
  output logic timeout
);

  localparam int SW = $clog2(SETTLE_FRAMES + 1);
  localparam int RW = $clog2(MAX_ROLL_FRAMES + 1);

  logic [SW-1:0] stillCnt, stillNext;
  logic [RW-1:0] rollCnt,  rollNext;

  always_comb begin
    stillNext = no_moving_flag ? stillCnt + SW'(1) : '0;
    rollNext  = rollCnt + RW'(1);
    settled   = startOfFrame && !clear && (stillNext == SW'(SETTLE_FRAMES));
    timeout   = startOfFrame && !clear && !settled && (rollNext == RW'(MAX_ROLL_FRAMES));
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      stillCnt <= '0;
      rollCnt  <= '0;
    end else if (clear) begin
      stillCnt <= '0;
      rollCnt  <= '0;
    end else if (startOfFrame) begin
      stillCnt <= stillNext;
      rollCnt  <= rollNext;
    end
  end

endmodule

// File: rtl/turn_sequencer.sv
// turn_sequencer: game-level shot/turn controller.
// Gates cue input, accumulates per-shot contact/pot events while balls roll,
// waits for the table to settle (or forces a stop), applies scoring and foul
// rules, passes the turn and detects the end of the game.
//   clk, resetN            clock / async active-low reset
//   startOfFrame           frame tick
//   shot_fire              cue strike request (taken only while aiming)
//   no_moving_flag         all balls still
//   collisions/ball_scored per-ball pulses from the hit datapath
//   respot_done            cue ball placed back
//   new_game               synchronous restart, any state
//   shot_enable, stop_all, cue_respawn, current_player, score0/1,
//   pocketed, foul, game_over, winner: all registered
// Optional build macro TURN_TIMEOUT_EN: aim time limit that fouls the
// player and passes the turn after AIM_TIMEOUT_FRAMES frames.
module turn_sequencer #(
  parameter int NUMBER_OF_BALLS    = 11,
  parameter int SETTLE_FRAMES      = 4,
  parameter int MAX_ROLL_FRAMES    = 1800,
  parameter int AIM_TIMEOUT_FRAMES = 600
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       startOfFrame,
  input  logic                       shot_fire,
  input  logic                       no_moving_flag,
  input  logic [NUMBER_OF_BALLS-1:0] collisions,
  input  logic [NUMBER_OF_BALLS-1:0] ball_scored,
  input  logic                       respot_done,
  input  logic                       new_game,
  output logic                       shot_enable,
  output logic                       stop_all,
  output logic                       cue_respawn,
  output logic                       current_player,
  output logic [3:0]                 score0,
  output logic [3:0]                 score1,
  output logic [NUMBER_OF_BALLS-1:0] pocketed,
  output logic                       foul,
  output logic                       game_over,
  output logic [1:0]                 winner
);

  import game_pkg::*;

  localparam int NB = NUMBER_OF_BALLS;
  // Object balls only; the cue ball never counts as pocketed.
  localparam logic [NB-1:0] OBJ_MASK = ~(NB'(1) << CUE_BALL);

  turnState_t     state;
  logic           cueContact, cuePotted;
  logic [3:0]     pottedCnt;
  logic [NB-1:0]  newPots;
  logic [3:0]     newPotCnt;
  logic           settled, rollTimeout, detClear;
  logic           foulNow, passTurn, allPocketed;
  logic [3:0]     nextScore0, nextScore1;

`ifdef TURN_TIMEOUT_EN
  localparam int AW = $clog2(AIM_TIMEOUT_FRAMES + 1);
  logic [AW-1:0] aimCnt;
`endif

  assign detClear = new_game || (state != S_ROLL);

  still_detector #(
    .SETTLE_FRAMES  (SETTLE_FRAMES),
    .MAX_ROLL_FRAMES(MAX_ROLL_FRAMES)
  ) uStill (
    .clk           (clk),
    .resetN        (resetN),
    .clear         (detClear),
    .startOfFrame  (startOfFrame),
    .no_moving_flag(no_moving_flag),
    .settled       (settled),
    .timeout       (rollTimeout)
  );

  // Only first-time pots count; a re-pulse of a pocketed ball is masked here.
  always_comb begin
    newPots   = ball_scored & ~pocketed & OBJ_MASK;
    newPotCnt = '0;
    for (int i = 0; i < NB; i++) newPotCnt = newPotCnt + 4'(newPots[i]);
  end

  always_comb begin
    foulNow     = cuePotted | ~cueContact;
    passTurn    = foulNow | (pottedCnt == 4'd0);
    allPocketed = &(pocketed | ~OBJ_MASK);
    nextScore0  = current_player ? score0 : satAdd(score0, pottedCnt);
    nextScore1  = current_player ? satAdd(score1, pottedCnt) : score1;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state          <= S_AIM;
      cueContact     <= 1'b0;
      cuePotted      <= 1'b0;
      pottedCnt      <= '0;
      shot_enable    <= 1'b0;
      stop_all       <= 1'b0;
      cue_respawn    <= 1'b0;
      current_player <= 1'b0;
      score0         <= '0;
      score1         <= '0;
      pocketed       <= '0;
      foul           <= 1'b0;
      game_over      <= 1'b0;
      winner         <= WIN_NONE;
`ifdef TURN_TIMEOUT_EN
      aimCnt         <= '0;
`endif
    end else if (new_game) begin
      // Restart wins over everything, including a coincident shot_fire.
      state          <= S_AIM;
      cueContact     <= 1'b0;
      cuePotted      <= 1'b0;
      pottedCnt      <= '0;
      shot_enable    <= 1'b0;
      stop_all       <= 1'b0;
      cue_respawn    <= 1'b0;
      current_player <= 1'b0;
      score0         <= '0;
      score1         <= '0;
      pocketed       <= '0;
      foul           <= 1'b0;
      game_over      <= 1'b0;
      winner         <= WIN_NONE;
`ifdef TURN_TIMEOUT_EN
      aimCnt         <= '0;
`endif
    end else begin
      stop_all <= 1'b0;
      case (state)
        S_AIM: begin
          cueContact <= 1'b0;
          cuePotted  <= 1'b0;
          pottedCnt  <= '0;
          if (shot_fire) begin
            state       <= S_ROLL;
            shot_enable <= 1'b0;
`ifdef TURN_TIMEOUT_EN
            aimCnt      <= '0;
`endif
          end else begin
            shot_enable <= 1'b1;
`ifdef TURN_TIMEOUT_EN
            if (startOfFrame) begin
              if (aimCnt + AW'(1) == AW'(AIM_TIMEOUT_FRAMES)) begin
                aimCnt         <= '0;
                foul           <= 1'b1;
                current_player <= ~current_player;
              end else begin
                aimCnt <= aimCnt + AW'(1);
              end
            end
`endif
          end
        end

        S_ROLL: begin
          if (collisions[CUE_BALL])  cueContact <= 1'b1;
          if (ball_scored[CUE_BALL]) cuePotted  <= 1'b1;
          pocketed  <= pocketed | newPots;
          pottedCnt <= pottedCnt + newPotCnt;
          if (settled) begin
            state <= S_RESOLVE;
          end else if (rollTimeout) begin
            stop_all <= 1'b1;
            state    <= S_RESOLVE;
          end
        end

        S_RESOLVE: begin
          foul           <= foulNow;
          score0         <= nextScore0;
          score1         <= nextScore1;
          current_player <= current_player ^ passTurn;
          if (allPocketed) begin
            state     <= S_OVER;
            game_over <= 1'b1;
            winner    <= winnerOf(nextScore0, nextScore1);
          end else if (cuePotted) begin
            state       <= S_RESPOT;
            cue_respawn <= 1'b1;
          end else begin
            state       <= S_AIM;
            shot_enable <= 1'b1;
          end
        end

        S_RESPOT: begin
          if (respot_done) begin
            cue_respawn <= 1'b0;
            shot_enable <= 1'b1;
            state       <= S_AIM;
          end
        end

        S_OVER: begin
          // Held until new_game or reset.
        end

        default: state <= S_AIM;
      endcase
    end
  end

endmodule
